// File: rtl/cordic_result_buffer_if.sv
// Byte-stream interface between the CORDIC result buffer and its consumer.
// The buffer drives data/tag/last/valid; the consumer answers with ready.
interface cordic_result_buffer_if #(
    parameter int W = 8
) ();
    logic [W-1:0] out_data;
    logic         out_tag;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_tag,
        output out_last,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_tag,
        input  out_last,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/cordic_result_buffer.sv
// Captures each CORDIC result on the rising edge of done, queues it in a small
// FIFO and serialises every entry as two bytes onto a registered valid/ready stream.
module cordic_result_buffer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clka,
    input  logic                   reset,
    input  logic                   done,
    input  logic [W-1:0]           res0,
    input  logic [W-1:0]           res1,
    input  logic                   mode_tag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow,
    input  logic                   clr_ovf,
    cordic_result_buffer_if.master stream
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic         tag;
        logic [W-1:0] r1;
        logic [W-1:0] r0;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1
    } state_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_d;
    logic          done_d;
    logic          cap;
    logic          accept;
    logic          pop;
    logic          xfer;
    state_t        state_q;
    state_t        state_d;
    logic [W-1:0]  hold_res1;
    logic [W-1:0]  data_d;
    logic          tag_d;

    // done_d resets high so a done already asserted at reset release is ignored.
    assign cap    = done & ~done_d;
    assign xfer   = stream.out_valid & stream.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign accept = cap & ((count != DEPTH_C) | pop);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = BYTE0;
                end
            end
            BYTE0: begin
                if (xfer) state_d = BYTE1;
            end
            BYTE1: begin
                if (xfer) begin
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_d = BYTE0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d = stream.out_data;
        tag_d  = stream.out_tag;
        if (pop) begin
            data_d = mem[rd_ptr].r0;
            tag_d  = mem[rd_ptr].tag;
        end else if (state_q == BYTE0 && state_d == BYTE1) begin
            data_d = hold_res1;
        end

        unique case ({accept, pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, race-free.
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            done_d           <= 1'b1;
            state_q          <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            full             <= 1'b0;
            overflow         <= 1'b0;
            hold_res1        <= '0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            stream.out_tag   <= 1'b0;
            stream.out_data  <= '0;
        end else begin
            done_d  <= done;
            state_q <= state_d;
            count   <= count_d;
            full    <= (count_d == DEPTH_C);

            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                hold_res1 <= mem[rd_ptr].r1;
            end

            if (cap && !accept) overflow <= 1'b1;
            else if (clr_ovf)   overflow <= 1'b0;

            stream.out_valid <= (state_d != IDLE);
            stream.out_last  <= (state_d == BYTE1);
            stream.out_data  <= data_d;
            stream.out_tag   <= tag_d;
        end
    end

    // NOTE: the storage array has no reset; count and pointers alone define which entries are valid.
    always_ff @(posedge clka) begin
        if (accept) mem[wr_ptr] <= entry_t'{tag: mode_tag, r1: res1, r0: res0};
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Self-checking bench for cordic_result_buffer: directed scenarios plus a
// randomized run scored against a queue-based model of the byte stream.
module tb_cordic_result_buffer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         tag;
    } byte_t;

    logic         clka = 1'b0;
    logic         reset;
    logic         done;
    logic [W-1:0] res0;
    logic [W-1:0] res1;
    logic         mode_tag;
    logic [2:0]   count;
    logic         full;
    logic         overflow;
    logic         clr_ovf;

    int checks = 0;
    int errors = 0;

    cordic_result_buffer_if #(.W(W)) bus ();

    cordic_result_buffer #(.W(W), .DEPTH(DEPTH)) dut (
        .clka     (clka),
        .reset    (reset),
        .done     (done),
        .res0     (res0),
        .res1     (res1),
        .mode_tag (mode_tag),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .clr_ovf  (clr_ovf),
        .stream   (bus)
    );

    always #5 clka = ~clka;

    // One-cycle done pulse; inputs change on the falling edge.
    task automatic pulse(input logic [W-1:0] r0, input logic [W-1:0] r1, input logic tag);
        done = 1'b1; res0 = r0; res1 = r1; mode_tag = tag;
        @(negedge clka);
        done = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_reset;
        reset = 1'b0; done = 1'b0; res0 = '0; res1 = '0; mode_tag = 1'b0;
        clr_ovf = 1'b0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clka);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_tag, bus.out_data, count, full, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_values got v=%b l=%b t=%b d=%h c=%0d f=%b o=%b want all zero",
                     bus.out_valid, bus.out_last, bus.out_tag, bus.out_data, count, full, overflow);
        end
        reset = 1'b1;
        @(negedge clka);
    endtask

    task automatic test_reset_mid;
        bus.out_ready = 1'b0;
        pulse(8'h21, 8'h31, 1'b0);
        pulse(8'h22, 8'h32, 1'b1);
        pulse(8'h23, 8'h33, 1'b0);
        checks++;
        if ({bus.out_valid, bus.out_data, count} !== {1'b1, 8'h21, 3'd2}) begin
            errors++;
            $display("FAIL mid_setup got v=%b d=%h c=%0d want v=1 d=21 c=2", bus.out_valid, bus.out_data, count);
        end
        done = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, count, overflow, full} !== '0) begin
            errors++;
            $display("FAIL mid_reset got v=%b c=%0d o=%b f=%b want 0", bus.out_valid, count, overflow, full);
        end
        @(negedge clka);
        reset = 1'b1;
        repeat (3) @(negedge clka);
        checks++;
        if ({bus.out_valid, count} !== '0) begin
            errors++;
            $display("FAIL release_done_high got v=%b c=%0d want v=0 c=0", bus.out_valid, count);
        end
        done = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_single;
        bus.out_ready = 1'b1;
        done = 1'b1; res0 = 8'h0A; res1 = 8'h00; mode_tag = 1'b0;
        @(negedge clka);
        done = 1'b0;
        checks++;
        if ({bus.out_valid, count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_capture got v=%b c=%0d want v=0 c=1", bus.out_valid, count);
        end
        @(negedge clka);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_tag} !== {1'b1, 8'h0A, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_byte0 got v=%b d=%h l=%b want v=1 d=0a l=0", bus.out_valid, bus.out_data, bus.out_last);
        end
        @(negedge clka);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL single_byte1 got v=%b d=%h l=%b want v=1 d=00 l=1", bus.out_valid, bus.out_data, bus.out_last);
        end
        @(negedge clka);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stall;
        bus.out_ready = 1'b0;
        done = 1'b1; res0 = 8'h0A; res1 = 8'h00; mode_tag = 1'b0;
        @(negedge clka);
        done = 1'b0;
        @(negedge clka);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h0A, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold cycle %0d got v=%b d=%h l=%b want v=1 d=0a l=0",
                         i, bus.out_valid, bus.out_data, bus.out_last);
            end
            if (i < 4) @(negedge clka);
        end
        bus.out_ready = 1'b1;
        @(negedge clka);
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL stall_byte1 got v=%b d=%h l=%b want v=1 d=00 l=1", bus.out_valid, bus.out_data, bus.out_last);
        end
        @(negedge clka);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle got v=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_long_pulse;
        byte_t got[$];
        bus.out_ready = 1'b1;
        done = 1'b1; res0 = 8'h33; res1 = 8'h44; mode_tag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clka);
            if (bus.out_valid) got.push_back('{bus.out_data, bus.out_last, bus.out_tag});
            if (i == 9) done = 1'b0;
        end
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL long_pulse_bytes got %0d bytes want 2", got.size());
        end else begin
            checks++;
            if ({got[0].data, got[0].last, got[0].tag, got[1].data, got[1].last, got[1].tag}
                !== {8'h33, 1'b0, 1'b1, 8'h44, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL long_pulse_data got %h/%b/%b %h/%b/%b want 33/0/1 44/1/1",
                         got[0].data, got[0].last, got[0].tag, got[1].data, got[1].last, got[1].tag);
            end
        end
    endtask

    // Drains n bytes with ready high and compares them against want[].
    task automatic drain_compare(input string name, input byte_t want[$]);
        int n = 0;
        int guard = 0;
        bus.out_ready = 1'b1;
        while (n < want.size() && guard < 40) begin
            if (bus.out_valid) begin
                checks++;
                if ({bus.out_data, bus.out_last, bus.out_tag} !== {want[n].data, want[n].last, want[n].tag}) begin
                    errors++;
                    $display("FAIL %s byte %0d got d=%h l=%b t=%b want d=%h l=%b t=%b", name, n,
                             bus.out_data, bus.out_last, bus.out_tag, want[n].data, want[n].last, want[n].tag);
                end
                n++;
            end
            @(negedge clka);
            guard++;
        end
        checks++;
        if (n != want.size()) begin
            errors++;
            $display("FAIL %s timeout got %0d bytes want %0d", name, n, want.size());
        end
    endtask

    task automatic test_overflow;
        byte_t want[$];
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) clr_ovf = 1'b1;
            done = 1'b1; res0 = W'(i); res1 = W'(8'h10 + i); mode_tag = i[0];
            @(negedge clka);
            done = 1'b0; clr_ovf = 1'b0;
            @(negedge clka);
        end
        checks++;
        if ({count, full, overflow, bus.out_valid, bus.out_data} !== {3'd4, 1'b1, 1'b1, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL overflow_state got c=%0d f=%b o=%b v=%b d=%h want c=4 f=1 o=1 v=1 d=01",
                     count, full, overflow, bus.out_valid, bus.out_data);
        end
        for (int i = 1; i <= 5; i++) begin
            want.push_back('{W'(i), 1'b0, i[0]});
            want.push_back('{W'(8'h10 + i), 1'b1, i[0]});
        end
        drain_compare("overflow_drain", want);
        repeat (2) @(negedge clka);
        checks++;
        if ({bus.out_valid, count, full, overflow} !== {1'b0, 3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL overflow_sticky got v=%b c=%0d f=%b o=%b want v=0 c=0 f=0 o=1",
                     bus.out_valid, count, full, overflow);
        end
        clr_ovf = 1'b1;
        @(negedge clka);
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %b want 0", overflow);
        end
    endtask

    task automatic test_full_simul;
        byte_t want[$];
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) pulse(W'(8'h50 + i), W'(8'h60 + i), 1'b0);
        checks++;
        if ({count, full} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL simul_setup got c=%0d f=%b want c=4 f=1", count, full);
        end
        bus.out_ready = 1'b1;
        @(negedge clka);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, 1'b1, 8'h61}) begin
            errors++;
            $display("FAIL simul_byte1 got v=%b l=%b d=%h want v=1 l=1 d=61", bus.out_valid, bus.out_last, bus.out_data);
        end
        done = 1'b1; res0 = 8'h77; res1 = 8'h78; mode_tag = 1'b1;
        @(negedge clka);
        done = 1'b0;
        checks++;
        if ({count, full, overflow, bus.out_data, bus.out_last} !== {3'd4, 1'b1, 1'b0, 8'h52, 1'b0}) begin
            errors++;
            $display("FAIL simul_capture got c=%0d f=%b o=%b d=%h l=%b want c=4 f=1 o=0 d=52 l=0",
                     count, full, overflow, bus.out_data, bus.out_last);
        end
        for (int i = 2; i <= 5; i++) begin
            want.push_back('{W'(8'h50 + i), 1'b0, 1'b0});
            want.push_back('{W'(8'h60 + i), 1'b1, 1'b0});
        end
        want.push_back('{8'h77, 1'b0, 1'b1});
        want.push_back('{8'h78, 1'b1, 1'b1});
        drain_compare("simul_drain", want);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_d;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(W'(8'hA0 + i), W'(8'hB0 + i), 1'b1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_d = k[0] ? W'(8'hB0 + k / 2) : W'(8'hA0 + k / 2);
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, exp_d, k[0]}) begin
                errors++;
                $display("FAIL back_to_back byte %0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         k, bus.out_valid, bus.out_data, bus.out_last, exp_d, k[0]);
            end
            @(negedge clka);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_idle got v=%b want 0", bus.out_valid);
        end
    endtask

    // Random traffic; pulses are issued only while no more than DEPTH results
    // are outstanding, which the DEPTH+1 capacity always absorbs.
    task automatic test_random;
        byte_t exp_q[$];
        byte_t e;
        byte_t prev;
        logic  prev_stall = 1'b0;
        int    outstanding = 0;
        for (int cyc = 0; cyc < 3000 + 60; cyc++) begin
            if (prev_stall) begin
                checks++;
                if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_tag} !== {1'b1, prev.data, prev.last, prev.tag}) begin
                    errors++;
                    $display("FAIL random_stable cyc %0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             cyc, bus.out_valid, bus.out_data, bus.out_last, prev.data, prev.last);
                end
            end
            bus.out_ready = (cyc >= 3000) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_extra cyc %0d got byte %h want none", cyc, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_data, bus.out_last, bus.out_tag} !== {e.data, e.last, e.tag}) begin
                        errors++;
                        $display("FAIL random_byte cyc %0d got d=%h l=%b t=%b want d=%h l=%b t=%b",
                                 cyc, bus.out_data, bus.out_last, bus.out_tag, e.data, e.last, e.tag);
                    end
                    if (e.last) outstanding--;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev = '{bus.out_data, bus.out_last, bus.out_tag};
            if (done) begin
                done = ($urandom_range(0, 1) == 1) && (cyc < 3000);
            end else if (cyc < 3000 && outstanding <= DEPTH && $urandom_range(0, 2) == 0) begin
                done = 1'b1;
                res0 = W'($urandom);
                res1 = W'($urandom);
                mode_tag = 1'($urandom);
                exp_q.push_back('{res0, 1'b0, mode_tag});
                exp_q.push_back('{res1, 1'b1, mode_tag});
                outstanding++;
            end
            @(negedge clka);
        end
        checks++;
        if (exp_q.size() != 0 || {bus.out_valid, count, overflow} !== '0) begin
            errors++;
            $display("FAIL random_end got pending=%0d v=%b c=%0d o=%b want 0", exp_q.size(), bus.out_valid, count, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_stall();
        test_long_pulse();
        test_overflow();
        test_full_simul();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
